// File: rtl/memory_pkg.sv
// Shared constants for the pipelined RAM: FSM states, read-latency bounds and
// the parameter sanity check used at elaboration.
package memory_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 4;

    function automatic bit cfg_ok(input int width, input int rd_latency);
        return (width > 0) && (width % 8 == 0) &&
               (rd_latency >= MIN_RD_LAT) && (rd_latency <= MAX_RD_LAT);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Response delay line: STAGES registers carrying {valid, err, data}.
// A synchronous flush drops everything in flight.
module mem_resp_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_err,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_err,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1]            err_pipe;
    logic [STAGES:1][WIDTH-1:0] data_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            err_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[1]  <= in_valid;
            err_pipe[1]  <= in_err;
            data_pipe[1] <= in_data;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                err_pipe[i]  <= err_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_err   = err_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];

endmodule

// File: rtl/memory_pipelined.sv
// Single-port RAM behind a valid/ready bus: byte strobes, configurable read
// latency, out-of-range error responses and a post-reset clear sequencer.
module memory_pipelined
    import memory_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  err,
    output logic                  init_done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!cfg_ok(WIDTH, RD_LATENCY)) begin : g_bad_cfg
        $error("memory_pipelined: WIDTH must be a multiple of 8 and RD_LATENCY within 1..4");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [IW-1:0]         idx;
    logic [WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]      merged;

    // rst gates accept so a request coinciding with reset never touches memory
    assign accept   = valid && ready && !rst;
    assign in_range = addr < ADDR_WIDTH'(DEPTH);
    assign idx      = addr[IW-1:0];
    assign rd_word  = mem[idx];

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            ptr       <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                state     <= RUN;
                ready     <= 1'b1;
                init_done <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the INIT sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[ptr[IW-1:0]] <= '0;
            end else if (accept && wr_rd && in_range) begin
                mem[idx] <= merged;
            end
        end
    end

    mem_resp_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_err    (accept && !in_range),
        .in_data   ((accept && !wr_rd && in_range) ? rd_word : '0),
        .out_valid (resp_valid),
        .out_err   (err),
        .out_data  (rdata)
    );

endmodule

// File: tb/tb_memory_pipelined.sv
// Bench for memory_pipelined: two instances (64 words / latency 3 and
// 48 words / latency 1) share one stimulus stream and are checked against a model.
module tb_memory_pipelined;

    localparam int W  = 16;
    localparam int AW = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic             wr_rd = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [W-1:0]     wdata = '0;
    logic [1:0]       wstrb = '0;
    logic [1:0]       rdy, rv, er, idn;
    logic [W-1:0]     rd0, rd1;

    always #5 clk = ~clk;

    memory_pipelined #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_a (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ready(rdy[0]), .resp_valid(rv[0]), .rdata(rd0), .err(er[0]),
        .init_done(idn[0]));

    memory_pipelined #(.WIDTH(16), .DEPTH(48), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ready(rdy[1]), .resp_valid(rv[1]), .rdata(rd1), .err(er[1]),
        .init_done(idn[1]));

    function automatic int dep_of(input int d);
        return (d == 0) ? 64 : 48;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory contents, ready after DEPTH clean cycles, and a schedule of
    // responses keyed by the edge on which each one becomes visible.
    logic [W-1:0] mm [2][64];
    bit           mrdy [2];
    int           mcnt [2];
    bit           sv [2][8];
    bit           se [2][8];
    logic [W-1:0] sd [2][8];
    bit           e_rv [2];
    bit           e_er [2];
    logic [W-1:0] e_rd [2];
    int           edge_n = 0;

    always @(posedge clk) begin : model
        bit           acc;
        bit           oor;
        int           ai;
        int           slot;
        logic [W-1:0] rdv;
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            acc = !rst && valid && mrdy[d];
            if (rst) begin
                for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
                mcnt[d] = 0;
                mrdy[d] = 1'b0;
            end else begin
                if (acc) begin
                    ai  = int'(addr);
                    oor = ai >= dep_of(d);
                    rdv = '0;
                    if (!oor) begin
                        if (wr_rd) begin
                            for (int b = 0; b < 2; b++)
                                if (wstrb[b]) mm[d][ai][8*b +: 8] = wdata[8*b +: 8];
                        end else begin
                            rdv = mm[d][ai];
                        end
                    end
                    slot = (edge_n + lat_of(d) - 1) % 8;
                    sv[d][slot] = 1'b1;
                    se[d][slot] = oor;
                    sd[d][slot] = rdv;
                end
                mcnt[d]++;
                if (mcnt[d] == dep_of(d)) begin
                    for (int j = 0; j < 64; j++) mm[d][j] = '0;
                    mrdy[d] = 1'b1;
                end
            end
            slot    = edge_n % 8;
            e_rv[d] = sv[d][slot];
            e_er[d] = sv[d][slot] ? se[d][slot] : 1'b0;
            e_rd[d] = sv[d][slot] ? sd[d][slot] : '0;
            sv[d][slot] = 1'b0;
        end
    end

    bit          chk_en = 0;
    int          cyc = 0;
    bit          lat_arm = 0;
    int          lat_cyc = -1;
    logic [16:0] qa [$];
    logic [16:0] qb [$];
    int          qc [$];

    always @(negedge clk) begin : compare
        logic [W-1:0] act_rd;
        cyc++;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                act_rd = (d == 0) ? rd0 : rd1;
                check($sformatf("ready%0d", d), 32'(rdy[d]), 32'(mrdy[d]));
                check($sformatf("init_done%0d", d), 32'(idn[d]), 32'(mrdy[d]));
                check($sformatf("resp_valid%0d", d), 32'(rv[d]), 32'(e_rv[d]));
                check($sformatf("rdata%0d", d), 32'(act_rd), 32'(e_rd[d]));
                if (e_rv[d]) check($sformatf("err%0d", d), 32'(er[d]), 32'(e_er[d]));
            end
            if (rv[0] === 1'b1) begin
                qa.push_back({er[0], rd0});
                qc.push_back(cyc);
                if (lat_arm) begin
                    lat_cyc = cyc;
                    lat_arm = 0;
                end
            end
            if (rv[1] === 1'b1) qb.push_back({er[1], rd1});
        end
    end

    function automatic logic [16:0] get_a(input int i);
        return (qa.size() > i) ? qa[i] : 17'h1ffff;
    endfunction

    function automatic logic [16:0] get_b(input int i);
        return (qb.size() > i) ? qb[i] : 17'h1ffff;
    endfunction

    task automatic issue(input bit w, input int a, input logic [W-1:0] dv, input logic [1:0] s);
        valid = 1'b1;
        wr_rd = w;
        addr  = a[AW-1:0];
        wdata = dv;
        wstrb = s;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    // Counts cycles with ready low on each instance until the 64-word one is ready.
    task automatic count_init(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) break;
            na++;
            if (rdy[1] !== 1'b1) nb++;
        end
        @(posedge clk);
        #1;
    endtask

    int na, nb, t0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;
        check("reset_ready", 32'(rdy), 32'h0);
        check("reset_resp_valid", 32'(rv), 32'h0);
        check("reset_rdata", 32'({rd1, rd0}), 32'h0);
        rst = 1'b0;
        count_init(na, nb);
        check("init_len_a", 32'(na), 32'd64);
        check("init_len_b", 32'(nb), 32'd48);

        // every word reads back zero; the 48-word instance errors above 47
        clear_q();
        for (int i = 0; i < 64; i++) issue(0, i, 16'h0, 2'b00);
        idle(6);
        check("init_rd_cnt_a", 32'(qa.size()), 32'd64);
        check("init_rd_cnt_b", 32'(qb.size()), 32'd64);
        for (int i = 0; i < 64; i++) begin
            check("init_rd_a", 32'(get_a(i)), 32'h0);
            check("init_rd_b", 32'(get_b(i)), (i < 48) ? 32'h0 : 32'h10000);
        end

        // byte strobes
        clear_q();
        issue(1, 5, 16'hABCD, 2'b11);
        issue(1, 5, 16'h1234, 2'b01);
        issue(0, 5, 16'h0, 2'b00);
        idle(6);
        check("strb_wr_resp_a", 32'(get_a(0)), 32'h0);
        check("strb_rd_a", 32'(get_a(2)), 32'h0AB34);
        check("strb_rd_b", 32'(get_b(2)), 32'h0AB34);

        // read-after-write on consecutive cycles, plus a wstrb=0 no-op
        clear_q();
        issue(1, 9, 16'h5A5A, 2'b11);
        issue(0, 9, 16'h0, 2'b00);
        issue(1, 9, 16'hFFFF, 2'b00);
        issue(0, 9, 16'h0, 2'b00);
        idle(6);
        check("raw_a", 32'(get_a(1)), 32'h05A5A);
        check("raw_b", 32'(get_b(1)), 32'h05A5A);
        check("nostrb_cnt_a", 32'(qa.size()), 32'd4);
        check("nostrb_a", 32'(get_a(3)), 32'h05A5A);

        // latency: back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) issue(1, i, 16'h1000 + 16'(i) * 16'h0101, 2'b11);
        idle(6);
        clear_q();
        t0 = cyc + 1;
        lat_arm = 1;
        for (int i = 0; i < 8; i++) issue(0, i, 16'h0, 2'b00);
        idle(8);
        check("lat_first_a", 32'(lat_cyc - t0), 32'd3);
        check("lat_cnt_a", 32'(qa.size()), 32'd8);
        check("lat_span_a", (qc.size() == 8) ? 32'(qc[7] - qc[0]) : 32'hffff, 32'd7);
        for (int i = 0; i < 8; i++)
            check("lat_data_a", 32'(get_a(i)), 32'(16'h1000 + 16'(i) * 16'h0101));

        // out-of-range on the 48-word instance; in range on the 64-word one
        clear_q();
        issue(1, 2, 16'h1111, 2'b11);
        issue(1, 50, 16'hFFFF, 2'b11);
        issue(0, 50, 16'h0, 2'b00);
        issue(0, 2, 16'h0, 2'b00);
        idle(6);
        check("err_wr_b", 32'(get_b(1)), 32'h10000);
        check("err_rd_b", 32'(get_b(2)), 32'h10000);
        check("err_alias_b", 32'(get_b(3)), 32'h01111);
        check("noerr_rd_a", 32'(get_a(2)), 32'h0FFFF);

        // reset with two reads in flight
        clear_q();
        issue(0, 1, 16'h0, 2'b00);
        issue(0, 2, 16'h0, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_init(na, nb);
        check("rerun_len_a", 32'(na), 32'd64);
        check("rerun_len_b", 32'(nb), 32'd48);
        check("flushed_a", 32'(qa.size()), 32'd0);
        check("early_resp_b", 32'(qb.size()), 32'd2);
        clear_q();
        issue(0, 5, 16'h0, 2'b00);
        idle(6);
        check("recleared_a", 32'(get_a(0)), 32'h0);
        check("recleared_b", 32'(get_b(0)), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
